ccsds_packet_parser: RTL and testbench
======================================

Name: ccsds_packet_parser

Overview:
- Parametrised successor to the fixed 32-bit packet-header stage of the telemetry decompression path.
- Accepts a word stream qualified by datavalid and decodes the two-word primary header (version, type, APID, sequence flags/count, length).
- Forwards payload words to the Rice decoder with a last marker. Filters packets by APID and flags version, length and sequence-continuity errors.

Parameters:
- DATA_W, 32, stream word width; header fields sit in the top 32 bits; must be >= 32.
- MAX_WORDS, 1024, largest payload word count accepted; must be <= 65536.
- APID_MASK, 11'h000, APID bits compared by the filter; 0 accepts every packet.
- APID_MATCH, 11'h000, required value of the masked APID bits.
- CNT_W, 16, width of the delivered-packet counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- datavalid  in  1  data holds a valid word this cycle.
- data  in  DATA_W  input stream word.
- packetdata  out  DATA_W  registered payload word.
- payload_valid  out  1  packetdata valid this cycle.
- payload_last  out  1  final payload word of the packet; only asserted with payload_valid.
- hdr_valid  out  1  one-cycle pulse: header decoded for a packet that is being delivered.
- apid  out  11  APID of the current packet.
- pkt_type  out  1  type bit.
- sec_hdr  out  1  secondary-header flag.
- seq_flags  out  2  sequence flags.
- seq_count  out  14  sequence count.
- seq_err  out  1  pulse with hdr_valid when continuity fails.
- len_err  out  1  pulse: packet dropped, length exceeds MAX_WORDS.
- ver_err  out  1  pulse: packet dropped, version not 0.
- filt_drop  out  1  pulse: packet dropped by the APID filter.
- pkt_cnt  out  CNT_W  count of delivered packets; saturates at all-ones.

Behaviour:
- Header format, with T = DATA_W-1 as the top bit:
  - word0[T:T-2]: version. word0[T-3]: type. word0[T-4]: sec_hdr. word0[T-5:T-15]: APID. word0[T-16:T-17]: seq_flags. word0[T-18:T-31]: seq_count.
  - word1[T:T-15]: L. The payload is L+1 words (17-bit arithmetic, range 1..65536). All remaining word1 bits are ignored.
- Reset:
  - All outputs go to 0 and the FSM goes to HDR0.
  - The last-sequence store is cleared and marked invalid.
  - pkt_cnt is cleared.
- FSM states: HDR0, HDR1, PAYLOAD, SKIP. Only cycles with datavalid=1 advance the FSM or the word counters. Idle gaps are allowed in any state and never produce outputs.
- HDR0: a valid word is latched as word0. Next state is HDR1.
- HDR1: a valid word is latched as word1. Decision priority, in order:
  - version != 0: ver_err, go to SKIP.
  - L+1 > MAX_WORDS: len_err, go to SKIP.
  - (APID & APID_MASK) != APID_MATCH: filt_drop, go to SKIP.
  - Otherwise go to PAYLOAD.
  - The error/drop pulse comes 1 cycle after the word1 cycle.
- Accepted header, 1 cycle after the word1 cycle:
  - hdr_valid pulses.
  - apid, pkt_type, sec_hdr, seq_flags and seq_count update and hold until the next accepted header.
  - seq_err=1 when the store is valid and seq_count != (stored+1) mod 2^14. The wrap 16383 -> 0 is legal.
  - The store updates to seq_count and becomes valid. The packet is delivered even when seq_err=1.
- Dropped packets never update apid or the sequence store and never pulse hdr_valid.
- PAYLOAD:
  - A word accepted in cycle t appears on packetdata with payload_valid in cycle t+1; latency 1.
  - The (L+1)th word also sets payload_last, increments pkt_cnt (saturating), and returns the FSM to HDR0.
- SKIP: discards L+1 valid words with no outputs, then returns to HDR0.
- Back-to-back: the cycle after a final payload or skip word may carry the next word0 with no bubble.
- packetdata holds its last value when payload_valid=0.
- Reset asserted mid-packet: the next cycle is the reset state; the partial packet produces no further outputs.
- Reset has priority over a coincident datavalid, which is ignored.

Test Plan:
1. APID 0x123, seq 5, L=3, four words A0..A3 back-to-back → hdr_valid on the cycle after word1; payload words one cycle later each; payload_last on A3; pkt_cnt=1; seq_err=0.
2. Two packets with seq 16383 then 0, then a third with seq 2 → seq_err only on the third; all three delivered; pkt_cnt=3.
3. MAX_WORDS=16, L=16 → len_err pulse; 17 words skipped; a following valid packet is delivered intact.
4. version=3 → ver_err only, even with L=0xFFFF and a filter miss; APID_MASK=0x7FF, APID_MATCH=0x010, APID 0x011 → filt_drop; apid output unchanged.
5. datavalid toggling 1/0 through header and payload → identical data, one-cycle latency per accepted word, no pulses during gaps.
6. Reset after 2 of 5 payload words, then a fresh packet with seq 9 → no more payload from the old packet; new packet delivered; seq_err=0; pkt_cnt=1.

Source files
------------

// File: rtl/ccsds_packet_parser.sv
// CCSDS primary-header parser: decodes the two-word header, filters packets by
// APID, flags version/length/sequence errors and forwards payload words with a
// last marker and a delivered-packet counter.
module ccsds_packet_parser #(
  parameter int          DATA_W     = 32,
  parameter int          MAX_WORDS  = 1024,
  parameter logic [10:0] APID_MASK  = 11'h000,
  parameter logic [10:0] APID_MATCH = 11'h000,
  parameter int          CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              datavalid,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] packetdata,
  output logic              payload_valid,
  output logic              payload_last,
  output logic              hdr_valid,
  output logic [10:0]       apid,
  output logic              pkt_type,
  output logic              sec_hdr,
  output logic [1:0]        seq_flags,
  output logic [13:0]       seq_count,
  output logic              seq_err,
  output logic              len_err,
  output logic              ver_err,
  output logic              filt_drop,
  output logic [CNT_W-1:0]  pkt_cnt
);

  localparam int T = DATA_W - 1;

  typedef enum logic [1:0] {HDR0, HDR1, PAYLOAD, SKIP} state_t;

  state_t      state, state_nxt;
  logic [31:0] word0;
  logic [15:0] remain, remain_nxt;
  logic [15:0] len_field;
  logic [16:0] len_words;
  logic        seq_vld;
  logic [13:0] seq_last;
  logic        seq_gap;
  logic        word0_ld, accept, ver_nxt, len_nxt, filt_nxt, pay_nxt, last_nxt;

  // word0 is held as its top 32 bits: [31:29] version, [28] type, [27] sec_hdr,
  // [26:16] APID, [15:14] seq flags, [13:0] seq count.
  assign len_field = data[T -: 16];
  assign len_words = {1'b0, len_field} + 17'd1;
  assign seq_gap   = seq_vld && (word0[13:0] != seq_last + 14'd1);

  // State register and remaining-word counter (counts down to the final word)
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= HDR0;
      remain <= '0;
    end else begin
      state  <= state_nxt;
      remain <= remain_nxt;
    end
  end

  // Next-state decode and per-word pulse generation; idle cycles change nothing
  always_comb begin
    state_nxt  = state;
    remain_nxt = remain;
    word0_ld   = 1'b0;
    accept     = 1'b0;
    ver_nxt    = 1'b0;
    len_nxt    = 1'b0;
    filt_nxt   = 1'b0;
    pay_nxt    = 1'b0;
    last_nxt   = 1'b0;
    if (datavalid) begin
      case (state)
        HDR0: begin
          word0_ld  = 1'b1;
          state_nxt = HDR1;
        end
        HDR1: begin
          remain_nxt = len_field;
          if (word0[31:29] != 3'd0) begin
            ver_nxt   = 1'b1;
            state_nxt = SKIP;
          end else if (int'({15'd0, len_words}) > MAX_WORDS) begin
            len_nxt   = 1'b1;
            state_nxt = SKIP;
          end else if ((word0[26:16] & APID_MASK) != APID_MATCH) begin
            filt_nxt  = 1'b1;
            state_nxt = SKIP;
          end else begin
            accept    = 1'b1;
            state_nxt = PAYLOAD;
          end
        end
        PAYLOAD: begin
          pay_nxt = 1'b1;
          if (remain == 16'd0) begin
            last_nxt  = 1'b1;
            state_nxt = HDR0;
          end else begin
            remain_nxt = remain - 16'd1;
          end
        end
        SKIP: begin
          if (remain == 16'd0) state_nxt = HDR0;
          else                 remain_nxt = remain - 16'd1;
        end
        default: state_nxt = HDR0;
      endcase
    end
  end

  // Header word 0 capture
  always_ff @(posedge clk) begin
    if (word0_ld) word0 <= data[T -: 32];
  end

  // Registered outputs, sequence store and delivered-packet counter
  always_ff @(posedge clk) begin
    if (reset) begin
      packetdata    <= '0;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      hdr_valid     <= 1'b0;
      apid          <= '0;
      pkt_type      <= 1'b0;
      sec_hdr       <= 1'b0;
      seq_flags     <= '0;
      seq_count     <= '0;
      seq_err       <= 1'b0;
      len_err       <= 1'b0;
      ver_err       <= 1'b0;
      filt_drop     <= 1'b0;
      pkt_cnt       <= '0;
      seq_vld       <= 1'b0;
      seq_last      <= '0;
    end else begin
      payload_valid <= pay_nxt;
      payload_last  <= last_nxt;
      hdr_valid     <= accept;
      seq_err       <= accept & seq_gap;
      len_err       <= len_nxt;
      ver_err       <= ver_nxt;
      filt_drop     <= filt_nxt;
      if (pay_nxt) packetdata <= data;
      if (accept) begin
        apid      <= word0[26:16];
        pkt_type  <= word0[28];
        sec_hdr   <= word0[27];
        seq_flags <= word0[15:14];
        seq_count <= word0[13:0];
        seq_last  <= word0[13:0];
        seq_vld   <= 1'b1;
      end
      if (last_nxt && (pkt_cnt != {CNT_W{1'b1}})) pkt_cnt <= pkt_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ccsds_packet_parser.sv
// Bench for ccsds_packet_parser: two instances (default parameters, and a
// small MAX_WORDS with a strict APID filter) share one stimulus stream.
// Expected outputs come from a packet-level reference model.
module tb_ccsds_packet_parser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, datavalid;
  logic [31:0] data;

  logic [31:0] a_pd, b_pd;
  logic        a_pv, a_pl, a_hv, a_typ, a_sec, a_se, a_len, a_ver, a_filt;
  logic        b_pv, b_pl, b_hv, b_typ, b_sec, b_se, b_len, b_ver, b_filt;
  logic [10:0] a_apid, b_apid;
  logic [1:0]  a_flags, b_flags;
  logic [13:0] a_seq, b_seq;
  logic [15:0] a_cnt, b_cnt;

  ccsds_packet_parser dut_a (
    .clk(clk), .reset(reset), .datavalid(datavalid), .data(data),
    .packetdata(a_pd), .payload_valid(a_pv), .payload_last(a_pl), .hdr_valid(a_hv),
    .apid(a_apid), .pkt_type(a_typ), .sec_hdr(a_sec), .seq_flags(a_flags),
    .seq_count(a_seq), .seq_err(a_se), .len_err(a_len), .ver_err(a_ver),
    .filt_drop(a_filt), .pkt_cnt(a_cnt)
  );

  ccsds_packet_parser #(
    .MAX_WORDS(16), .APID_MASK(11'h7FF), .APID_MATCH(11'h010)
  ) dut_b (
    .clk(clk), .reset(reset), .datavalid(datavalid), .data(data),
    .packetdata(b_pd), .payload_valid(b_pv), .payload_last(b_pl), .hdr_valid(b_hv),
    .apid(b_apid), .pkt_type(b_typ), .sec_hdr(b_sec), .seq_flags(b_flags),
    .seq_count(b_seq), .seq_err(b_se), .len_err(b_len), .ver_err(b_ver),
    .filt_drop(b_filt), .pkt_cnt(b_cnt)
  );

  typedef struct packed { logic rst; logic vld; logic [31:0] data; } cyc_t;
  typedef struct packed {
    logic [31:0] pd; logic pv; logic pl; logic hv; logic [10:0] apid;
    logic typ; logic sec; logic [1:0] flags; logic [13:0] seq;
    logic se; logic len; logic ver; logic filt; logic [15:0] cnt;
  } exp_t;
  typedef struct packed { cyc_t in; exp_t ea; exp_t eb; } vec_t;
  typedef struct { int cyc; bit b; int fld; logic [31:0] val; string name; } hand_t;

  localparam int F_HV = 0, F_SE = 1, F_LAST = 2, F_CNT = 3;
  localparam int F_LEN = 4, F_VER = 5, F_FILT = 6, F_APID = 7;

  cyc_t  stim[$];
  exp_t  exp_a[$], exp_b[$];
  vec_t  vecs[$];
  hand_t hand[$];
  int    checks = 0;
  int    errors = 0;

  function automatic void push_word(input logic [31:0] w);
    stim.push_back({1'b0, 1'b1, w});
  endfunction

  function automatic void push_idle(input int n);
    for (int k = 0; k < n; k++) stim.push_back({1'b0, 1'b0, 32'($urandom)});
  endfunction

  // Reset cycles carry random datavalid/data, which must be ignored.
  function automatic void push_rst(input int n);
    for (int k = 0; k < n; k++) stim.push_back({1'b1, 1'($urandom), 32'($urandom)});
  endfunction

  function automatic void gapf(input int gap);
    if (gap == 1) push_idle(1);
    else if (gap == 2) push_idle(int'($urandom % 3));
  endfunction

  function automatic void add_hand(input int cyc, input bit b, input int fld,
                                   input logic [31:0] val, input string name);
    hand_t h;
    h.cyc = cyc; h.b = b; h.fld = fld; h.val = val; h.name = name;
    hand.push_back(h);
  endfunction

  // Emits one packet; send = number of payload words actually sent.
  function automatic void push_pkt(input logic [2:0] ver, input logic [10:0] ap,
                                   input logic [13:0] sq, input logic [15:0] len,
                                   input int gap, input int send,
                                   output int w1, output int lw);
    logic [31:0] w0;
    w0 = {ver, 1'($urandom), 1'($urandom), ap, 2'($urandom), sq};
    push_word(w0);
    gapf(gap);
    w1 = stim.size();
    push_word({len, 16'($urandom)});
    gapf(gap);
    lw = -1;
    for (int k = 0; k < send; k++) begin
      lw = stim.size();
      push_word($urandom);
      if (k != send - 1) gapf(gap);
    end
  endfunction

  // Packet-level reference: walks the word stream, splitting it into
  // header/payload by word position, and records the outputs expected
  // after each clock edge.
  function automatic void run_model(input int maxw, input logic [10:0] mask,
                                    input logic [10:0] match, input bit to_b);
    exp_t        e;
    int          pos, nwords, k;
    bit          deliver, sv;
    logic [31:0] w0;
    logic [13:0] sl;
    e = '0; pos = 0; nwords = 0; k = 0; deliver = 0; sv = 0; sl = '0; w0 = '0;
    for (int i = 0; i < stim.size(); i++) begin
      e.pv = 0; e.pl = 0; e.hv = 0; e.se = 0; e.len = 0; e.ver = 0; e.filt = 0;
      if (stim[i].rst) begin
        e = '0; pos = 0; sv = 0; sl = '0;
      end else if (stim[i].vld) begin
        if (pos == 0) begin
          w0 = stim[i].data; pos = 1;
        end else if (pos == 1) begin
          nwords = int'(stim[i].data[31:16]) + 1;
          k = 0; pos = 2; deliver = 0;
          if (w0[31:29] != 3'd0) e.ver = 1;
          else if (nwords > maxw) e.len = 1;
          else if ((w0[26:16] & mask) != match) e.filt = 1;
          else begin
            deliver = 1;
            e.hv = 1; e.apid = w0[26:16]; e.typ = w0[28]; e.sec = w0[27];
            e.flags = w0[15:14]; e.seq = w0[13:0];
            e.se = sv && (int'(w0[13:0]) != (int'(sl) + 1) % 16384);
            sl = w0[13:0]; sv = 1;
          end
        end else begin
          k++;
          if (deliver) begin
            e.pv = 1; e.pd = stim[i].data; e.pl = (k == nwords);
            if (k == nwords && e.cnt != 16'hFFFF) e.cnt = e.cnt + 16'd1;
          end
          if (k == nwords) pos = 0;
        end
      end
      if (to_b) exp_b.push_back(e);
      else      exp_a.push_back(e);
    end
  endfunction

  function automatic void build();
    int          w1, lw, send, gap;
    logic [2:0]  v;
    logic [10:0] ap;
    logic [15:0] len;
    logic [13:0] rs;
    push_rst(2);
    add_hand(1, 0, F_CNT, 0, "reset_cnt_a");
    add_hand(1, 1, F_APID, 0, "reset_apid_b");
    // APID 0x123, seq 5, four payload words back to back
    push_pkt(3'd0, 11'h123, 14'd5, 16'd3, 0, 4, w1, lw);
    add_hand(w1, 0, F_HV, 1, "t1_hdr_a");
    add_hand(w1, 0, F_SE, 0, "t1_seqerr_a");
    add_hand(lw - 1, 0, F_LAST, 0, "t1_notlast_a");
    add_hand(lw, 0, F_LAST, 1, "t1_last_a");
    add_hand(lw, 0, F_CNT, 1, "t1_cnt_a");
    add_hand(w1, 1, F_FILT, 1, "t1_filt_b");
    // Sequence wrap 16383 -> 0 is legal, 0 -> 2 is not
    push_rst(1);
    push_pkt(3'd0, 11'h010, 14'd16383, 16'd1, 0, 2, w1, lw);
    add_hand(w1, 0, F_SE, 0, "t2_wrap1_a");
    push_pkt(3'd0, 11'h010, 14'd0, 16'd0, 0, 1, w1, lw);
    add_hand(w1, 0, F_SE, 0, "t2_wrap2_a");
    push_pkt(3'd0, 11'h010, 14'd2, 16'd2, 0, 3, w1, lw);
    add_hand(w1, 0, F_SE, 1, "t2_gap_a");
    add_hand(lw, 0, F_CNT, 3, "t2_cnt_a");
    add_hand(lw, 1, F_CNT, 3, "t2_cnt_b");
    // 17-word packet: too long for the 16-word instance
    push_pkt(3'd0, 11'h010, 14'd3, 16'd16, 0, 17, w1, lw);
    add_hand(w1, 1, F_LEN, 1, "t3_len_b");
    add_hand(w1, 1, F_HV, 0, "t3_nohdr_b");
    add_hand(w1, 0, F_HV, 1, "t3_hdr_a");
    push_pkt(3'd0, 11'h010, 14'd4, 16'd1, 0, 2, w1, lw);
    add_hand(w1, 1, F_HV, 1, "t3_next_hdr_b");
    add_hand(lw, 1, F_LAST, 1, "t3_next_last_b");
    add_hand(lw, 1, F_CNT, 4, "t3_next_cnt_b");
    // Filter miss keeps the previous APID
    push_pkt(3'd0, 11'h011, 14'd5, 16'd1, 0, 2, w1, lw);
    add_hand(w1, 1, F_FILT, 1, "t4_filt_b");
    add_hand(w1, 1, F_APID, 32'h010, "t4_apid_b");
    add_hand(w1, 0, F_APID, 32'h011, "t4_apid_a");
    // Version error outranks length error and filter miss
    push_pkt(3'd3, 11'h011, 14'd6, 16'hFFFF, 0, 0, w1, lw);
    add_hand(w1, 1, F_VER, 1, "t4_ver_b");
    add_hand(w1, 1, F_LEN, 0, "t4_nolen_b");
    add_hand(w1, 1, F_FILT, 0, "t4_nofilt_b");
    add_hand(w1, 0, F_VER, 1, "t4_ver_a");
    push_idle(3);
    push_rst(1);
    // Alternating idle cycles through header and payload
    push_pkt(3'd0, 11'h010, 14'd7, 16'd3, 1, 4, w1, lw);
    add_hand(w1, 0, F_HV, 1, "t5_hdr_a");
    add_hand(lw, 1, F_LAST, 1, "t5_last_b");
    push_idle(2);
    // Reset mid-payload, then a fresh packet
    push_pkt(3'd0, 11'h010, 14'd20, 16'd4, 0, 2, w1, lw);
    push_rst(1);
    push_idle(2);
    push_pkt(3'd0, 11'h010, 14'd9, 16'd1, 0, 2, w1, lw);
    add_hand(w1, 0, F_SE, 0, "t6_seqerr_a");
    add_hand(lw, 0, F_CNT, 1, "t6_cnt_a");
    add_hand(lw, 1, F_CNT, 1, "t6_cnt_b");
    // Randomised traffic
    rs = 14'd100;
    for (int p = 0; p < 40; p++) begin
      v = ($urandom % 8 == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      case ($urandom % 4)
        0:       ap = 11'h010;
        1:       ap = 11'h011;
        2:       ap = 11'h123;
        default: ap = 11'($urandom);
      endcase
      if ($urandom % 5 == 0) rs = 14'($urandom);
      len  = 16'($urandom % 20);
      gap  = int'($urandom % 3);
      send = ($urandom % 10 == 0) ? int'($urandom % (int'(len) + 1)) : int'(len) + 1;
      push_pkt(v, ap, rs, len, gap, send, w1, lw);
      if (send < int'(len) + 1) push_rst(1);
      if ($urandom % 4 == 0) push_idle(int'($urandom % 4));
      rs = rs + 14'd1;
    end
    push_idle(2);
  endfunction

  function automatic logic [31:0] getf(input exp_t a, input int fld);
    case (fld)
      F_HV:    return {31'd0, a.hv};
      F_SE:    return {31'd0, a.se};
      F_LAST:  return {31'd0, a.pl};
      F_CNT:   return {16'd0, a.cnt};
      F_LEN:   return {31'd0, a.len};
      F_VER:   return {31'd0, a.ver};
      F_FILT:  return {31'd0, a.filt};
      default: return {21'd0, a.apid};
    endcase
  endfunction

  task automatic cmp(input string nm, input int i, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc %0d actual %h required %h", nm, i, act, req);
    end
  endtask

  task automatic check_all(input int i);
    exp_t aa, ab, ea, eb;
    aa = {a_pd, a_pv, a_pl, a_hv, a_apid, a_typ, a_sec, a_flags, a_seq, a_se, a_len, a_ver, a_filt, a_cnt};
    ab = {b_pd, b_pv, b_pl, b_hv, b_apid, b_typ, b_sec, b_flags, b_seq, b_se, b_len, b_ver, b_filt, b_cnt};
    ea = vecs[i].ea;
    eb = vecs[i].eb;
    cmp("a_payload", i, {30'd0, aa.pv, aa.pl, aa.pd}, {30'd0, ea.pv, ea.pl, ea.pd});
    cmp("a_header", i, {33'd0, aa.hv, aa.apid, aa.typ, aa.sec, aa.flags, aa.seq, aa.se},
                       {33'd0, ea.hv, ea.apid, ea.typ, ea.sec, ea.flags, ea.seq, ea.se});
    cmp("a_errors", i, {61'd0, aa.len, aa.ver, aa.filt}, {61'd0, ea.len, ea.ver, ea.filt});
    cmp("a_pkt_cnt", i, {48'd0, aa.cnt}, {48'd0, ea.cnt});
    cmp("b_payload", i, {30'd0, ab.pv, ab.pl, ab.pd}, {30'd0, eb.pv, eb.pl, eb.pd});
    cmp("b_header", i, {33'd0, ab.hv, ab.apid, ab.typ, ab.sec, ab.flags, ab.seq, ab.se},
                       {33'd0, eb.hv, eb.apid, eb.typ, eb.sec, eb.flags, eb.seq, eb.se});
    cmp("b_errors", i, {61'd0, ab.len, ab.ver, ab.filt}, {61'd0, eb.len, eb.ver, eb.filt});
    cmp("b_pkt_cnt", i, {48'd0, ab.cnt}, {48'd0, eb.cnt});
    foreach (hand[h]) begin
      if (hand[h].cyc == i)
        cmp(hand[h].name, i, {32'd0, getf(hand[h].b ? ab : aa, hand[h].fld)}, {32'd0, hand[h].val});
    end
  endtask

  initial begin
    reset = 1'b1;
    datavalid = 1'b0;
    data = '0;
    build();
    run_model(1024, 11'h000, 11'h000, 1'b0);
    run_model(16, 11'h7FF, 11'h010, 1'b1);
    for (int i = 0; i < stim.size(); i++) vecs.push_back({stim[i], exp_a[i], exp_b[i]});
    for (int i = 0; i < vecs.size(); i++) begin
      reset     = vecs[i].in.rst;
      datavalid = vecs[i].in.vld;
      data      = vecs[i].in.data;
      @(posedge clk);
      #1;
      check_all(i);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
